// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing one FIFO write port among N_REQ producers
// Grants one producer at a time for bursts of up to MAX_BURST beats, stalling while the FIFO is full.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int IDW       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  input  logic                full,
  output logic                wr_en,
  output logic [DW-1:0]       wr_data,
  output logic [IDW-1:0]      owner,
  output logic                busy
);

  localparam int BCW = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] rr_ptr;
  logic [BCW-1:0] burst_cnt;

  logic           owner_req;
  logic [DW-1:0]  owner_data;
  logic           beat;
  logic           last_beat;
  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner == IDW'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DW +: DW];
      end
    end
  end

  // Scan from rr_ptr upward (mod N_REQ); the first requester found wins.
  always_comb begin
    sel   = rr_ptr;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = IDW'((32'(rr_ptr) + 32'(i)) % N_REQ);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // rst in the beat term voids any beat that coincides with reset.
  assign beat      = (state == S_GRANT) && owner_req && !full && rst;
  assign last_beat = beat && (burst_cnt == BCW'(MAX_BURST - 1));
  assign next_ptr  = (owner == IDW'(N_REQ - 1)) ? '0 : owner + 1'b1;

  assign wr_en   = beat;
  assign wr_data = beat ? owner_data : '0;
  assign gnt     = beat ? (N_REQ'(1) << owner) : '0;
  assign busy    = (state == S_GRANT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (found) begin
        state     <= S_GRANT;
        owner     <= sel;
        burst_cnt <= '0;
      end
    end else begin
      if (!owner_req) begin
        state  <= S_IDLE;
        rr_ptr <= next_ptr;
      end else if (last_beat) begin
        state     <= S_IDLE;
        rr_ptr    <= next_ptr;
        burst_cnt <= '0;
      end else if (beat) begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  gnt, gnt1;
  logic        wr_en, wr_en1;
  logic [7:0]  wr_data, wr_data1;
  logic [1:0]  owner, owner1;
  logic        busy, busy1;

  logic [7:0]  pdata [4];
  int          tests = 0;
  int          fails = 0;
  logic        chk_b1 = 1'b0;
  int          n1 = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = pdata[i];
  end

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(4), .IDW(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .full(full),
    .wr_en(wr_en), .wr_data(wr_data), .owner(owner), .busy(busy)
  );

  fifo_wr_arbiter #(.N_REQ(4), .DW(8), .MAX_BURST(1), .IDW(2)) u_dut1 (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt1), .full(full),
    .wr_en(wr_en1), .wr_data(wr_data1), .owner(owner1), .busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ew, input logic [3:0] eg,
                         input logic [1:0] eo, input logic eb, input logic [7:0] ed);
    chk({tag, ".wr_en"},   32'(wr_en),   32'(ew));
    chk({tag, ".gnt"},     32'(gnt),     32'(eg));
    chk({tag, ".owner"},   32'(owner),   32'(eo));
    chk({tag, ".busy"},    32'(busy),    32'(eb));
    chk({tag, ".wr_data"}, 32'(wr_data), 32'(ed));
  endtask

  // One clock cycle: inputs were set at the negedge, check after settling, then let producers advance.
  task automatic cyc(input string tag, input logic ew, input logic [3:0] eg,
                     input logic [1:0] eo, input logic eb, input logic [7:0] ed);
    #1;
    chk_all(tag, ew, eg, eo, eb, ed);
    if (chk_b1) begin
      chk({tag, ".b1_wr_en"}, 32'(wr_en1), 32'(n1 % 2));
      if (n1 % 2 == 1) chk({tag, ".b1_owner"}, 32'(owner1), 32'(((n1 - 1) / 2) % 4));
      n1++;
    end
    for (int i = 0; i < 4; i++) if (gnt[i]) pdata[i] = pdata[i] + 8'd1;
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic [1:0] eo);
    cyc(tag, 1'b0, 4'b0000, eo, 1'b0, 8'h00);
  endtask

  task automatic beat(input string tag, input logic [1:0] id, input logic [7:0] ed);
    logic [3:0] g;
    g = 4'b0001 << id;
    cyc(tag, 1'b1, g, id, 1'b1, ed);
  endtask

  task automatic stall(input string tag, input logic [1:0] id);
    cyc(tag, 1'b0, 4'b0000, id, 1'b1, 8'h00);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_all(tag, 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst  = 1'b0;
    req  = '0;
    full = 1'b0;
    for (int i = 0; i < 4; i++) pdata[i] = '0;

    // 1: single producer, continuous request, bursts of 4 then one idle cycle
    do_reset("t1_rst");
    req = 4'b0100;
    pdata[2] = 8'hA0;
    for (int b = 0; b < 2; b++) begin
      idle("t1_idle", (b == 0) ? 2'd0 : 2'd2);
      for (int k = 0; k < 4; k++) beat("t1_beat", 2'd2, 8'hA0 + 8'(4*b + k));
    end
    req = '0;
    idle("t1_end", 2'd2);

    // 2: all producers requesting, rotation 0,1,2,3,0; MAX_BURST=1 instance alternates
    do_reset("t2_rst");
    for (int i = 0; i < 4; i++) pdata[i] = 8'h10 * 8'(i + 1);
    req    = 4'b1111;
    chk_b1 = 1'b1;
    n1     = 0;
    for (int g = 0; g < 5; g++) begin
      idle("t2_idle", (g == 0) ? 2'd0 : 2'((g - 1) % 4));
      for (int k = 0; k < 4; k++)
        beat("t2_beat", 2'(g % 4), 8'h10 * 8'((g % 4) + 1) + 8'(4*(g/4) + k));
    end
    chk_b1 = 1'b0;

    // 3: full for 3 cycles after beat 2 of a burst
    req = 4'b0010;
    pdata[1] = 8'h50;
    idle("t3_idle", 2'd0);
    beat("t3_b0", 2'd1, 8'h50);
    beat("t3_b1", 2'd1, 8'h51);
    full = 1'b1;
    for (int s = 0; s < 3; s++) stall("t3_stall", 2'd1);
    full = 1'b0;
    beat("t3_b2", 2'd1, 8'h52);
    beat("t3_b3", 2'd1, 8'h53);
    req = '0;
    idle("t3_end", 2'd1);

    // 4: producer 1 drops after 2 beats; rr_ptr=2 skips idle producer 2 and grants 3
    req = 4'b0010;
    pdata[1] = 8'h60;
    pdata[3] = 8'h70;
    idle("t4_idle", 2'd1);
    req = 4'b1010;
    beat("t4_b0", 2'd1, 8'h60);
    beat("t4_b1", 2'd1, 8'h61);
    req = 4'b1000;
    stall("t4_drop", 2'd1);
    idle("t4_rearb", 2'd1);
    beat("t4_g3b0", 2'd3, 8'h70);
    beat("t4_g3b1", 2'd3, 8'h71);

    // 5: reset mid-burst voids the beat immediately; restart from producer 0
    rst = 1'b0;
    #1;
    chk_all("t5_async", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    pdata[0] = 8'h80;
    idle("t5_idle", 2'd0);
    beat("t5_b0", 2'd0, 8'h80);

    // 6: FIFO full while arbitrating: grant taken, beats wait for full=0
    do_reset("t6_rst");
    req  = 4'b0001;
    full = 1'b1;
    pdata[0] = 8'h90;
    idle("t6_idle", 2'd0);
    stall("t6_stall0", 2'd0);
    stall("t6_stall1", 2'd0);
    full = 1'b0;
    beat("t6_b0", 2'd0, 8'h90);
    beat("t6_b1", 2'd0, 8'h91);
    req = '0;
    stall("t6_release", 2'd0);
    idle("t6_end", 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
